pc_ctrl: RTL
============

Name: pc_ctrl

Overview:
- Program-counter stage fed directly by the instruction decoder. Each cycle it consumes the decoder's PC mode, halt request and wait-for-interrupt request, and produces the next fetch address.
- Holds the PC register and a hardware return-address stack for subroutine call and return.
- Owns the core run/halt state.
- Its pc_o drives instruction memory, which supplies the opcode back to the decoder.

Parameters:
- PC_W, 8, PC and address width in bits.
- STACK_DEPTH, 4, return-stack entries; must be a power of two and at least 2.
- RESET_VEC, 0, PC value after reset and after a return from an empty stack.
- OFS_W, 6, width of the signed relative branch offset.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset, synchronous, active-high
- stall_i  in  1  freeze all state this cycle (memory wait)
- mode_pc_i  in  modePC  decoder PC mode: INCREMENT, RELATIVE, SUBROUTINE, RETURN
- offset_i  in  OFS_W  signed branch offset, used for RELATIVE
- target_i  in  PC_W  absolute subroutine entry address, used for SUBROUTINE
- halt_core_i  in  1  decoder halt request
- wfi_core_i  in  1  decoder wait request; the decoder clears it once ext_int is seen
- pc_o  out  PC_W  current fetch address
- halted_o  out  1  core is halted
- sp_o  out  $clog2(STACK_DEPTH)+1  number of occupied stack entries
- stk_ovf_o  out  1  sticky: a push was made to a full stack
- stk_unf_o  out  1  sticky: a pop was made from an empty stack

Behaviour:
- One clock domain, clk_i; reset is synchronous and active-high on rst_i.
- Reset values:
  - pc_o = RESET_VEC, halted_o = 0, sp_o = 0, stk_ovf_o = 0, stk_unf_o = 0.
  - All stack entries are cleared to 0.
  - Reset takes priority over every other input, including in HALTED and during stall.
- FSM states: RUN and HALTED.
  - RUN to HALTED: halt_core_i = 1 and stall_i = 0. The PC is not updated on that edge.
  - HALTED is left only by reset. In HALTED all inputs except rst_i are ignored and pc_o is frozen.
- Next-PC priority in RUN, evaluated on each rising edge:
  1. stall_i = 1: hold PC, stack and flags.
  2. halt_core_i = 1: enter HALTED, hold PC.
  3. wfi_core_i = 1: hold PC and do not touch the stack. Fetch re-presents the WFI until the decoder drops wfi_core_i, which turns the same instruction into an INCREMENT.
  4. mode_pc_i selects the update:
     - INCREMENT: pc + 1.
     - RELATIVE: pc + sign-extended offset_i.
     - SUBROUTINE: push pc + 1, then pc = target_i.
     - RETURN: if sp > 0, pop and pc = popped value. If sp = 0, pc = RESET_VEC and set stk_unf_o; sp stays 0.
- All PC arithmetic is modulo 2^PC_W; wrap-around is legal and silent. RELATIVE offset 0 is a self-loop.
- Full stack (sp = STACK_DEPTH) on SUBROUTINE:
  - Set stk_ovf_o.
  - The stack behaves circularly: the new entry overwrites the oldest, sp stays STACK_DEPTH, and the jump still occurs.
- Latency: pc_o is registered and reflects the decision one cycle after the inputs are presented. The stack is written and read on the same edge as the PC update.
- Simultaneous events:
  - halt beats wfi, and wfi beats mode, so a push or pop never happens on a halt or wfi cycle.
  - Sticky flags clear only on reset.

Optional Feature:
- Macro: PC_STACK_FAULT_HALT_EN.
- Defined: an overflow or underflow event sets its sticky flag and also enters HALTED on the same edge.
  - Overflow: no push, no jump; PC holds the SUBROUTINE address.
  - Underflow: PC holds the RETURN address, not RESET_VEC.
- Undefined: the circular-overwrite and return-to-RESET_VEC behaviour above applies, and the core keeps running.

Decomposition:
- Existing pico package: modePC is already there. Add to it:
  - PC_W and OFS_W defaults as localparams.
  - A two-state enum pcState (S_RUN, S_HALTED).
- Sub-module ret_stack: parameterised LIFO with push_i, pop_i, din_i, dout_o, count_o, full_o and empty_o. It implements circular overwrite when full and is instantiated once in pc_ctrl.

Test Plan:
- Reset, then 5 cycles of INCREMENT -> pc_o = 0,1,2,3,4,5. Hold pc = 255 with INCREMENT -> pc_o = 0.
- pc = 10, RELATIVE with offset_i = -3 (6'h3D) -> pc_o = 7. Then offset_i = +5 -> pc_o = 12.
- pc = 4, SUBROUTINE target_i = 40 -> pc_o = 40, sp_o = 1. Then RETURN -> pc_o = 5, sp_o = 0.
- Five nested SUBROUTINE calls from pc = 1,2,3,4,5 (depth 4) -> stk_ovf_o = 1, sp_o = 4. Four RETURNs yield 6, 5, 4, 3. A fifth RETURN -> pc_o = 0 and stk_unf_o = 1.
  - With PC_STACK_FAULT_HALT_EN: the fifth call leaves pc_o at 5 and halted_o = 1.
- pc = 20, wfi_core_i = 1 for 3 cycles -> pc_o stays 20. Then wfi_core_i = 0 with INCREMENT -> pc_o = 21.
- pc = 30, halt_core_i = 1 together with SUBROUTINE -> halted_o = 1, pc_o = 30, sp_o unchanged. Further inputs give no change. rst_i = 1 -> pc_o = 0, halted_o = 0.
  - stall_i = 1 for 2 cycles with RELATIVE -> no PC change.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared pico core types: decoder PC modes, PC-stage state encoding and
// default widths used by the program-counter stage.
package pico_pkg;

  localparam int PC_W_DEFAULT  = 8;
  localparam int OFS_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    INCREMENT  = 2'd0,
    RELATIVE   = 2'd1,
    SUBROUTINE = 2'd2,
    RETURN     = 2'd3
  } modePC;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } pcState;

endpackage

// File: rtl/pc_ctrl_ret_stack.sv
// Return-address LIFO. When full, a push overwrites the oldest entry so the
// most recent DEPTH return addresses are always kept.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [PTR_W-1:0] top_dec_s;
  logic [CNT_W-1:0] count_r;

  // top_r points at the next free slot; it wraps, which gives the overwrite
  assign top_dec_s = top_r - PTR_W'(1);
  assign dout_o    = mem_r[top_dec_s];
  assign count_o   = count_r;
  assign full_o    = (count_r == CNT_W'(DEPTH));
  assign empty_o   = (count_r == {CNT_W{1'b0}});

  // Stack storage, pointer and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_r   <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (push_i) begin
      mem_r[top_r] <= din_i;
      top_r        <= top_r + PTR_W'(1);
      if (!full_o) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end else if (pop_i && !empty_o) begin
      top_r   <= top_dec_s;
      count_r <= count_r - CNT_W'(1);
    end else begin
      top_r   <= top_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter stage: next-PC selection, return-address stack and run/halt
// state. Define PC_STACK_FAULT_HALT_EN to halt on stack overflow/underflow.
module pc_ctrl
  import pico_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEFAULT,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC   = {PC_W{1'b0}},
  parameter int              OFS_W       = OFS_W_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_i,
  input  modePC                        mode_pc_i,
  input  logic [OFS_W-1:0]             offset_i,
  input  logic [PC_W-1:0]              target_i,
  input  logic                         halt_core_i,
  input  logic                         wfi_core_i,
  output logic [PC_W-1:0]              pc_o,
  output logic                         halted_o,
  output logic [$clog2(STACK_DEPTH):0] sp_o,
  output logic                         stk_ovf_o,
  output logic                         stk_unf_o
);

  pcState          state_r;
  pcState          state_next;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] pc_rel_s;
  logic [PC_W-1:0] stk_dout_s;
  logic            push_s;
  logic            pop_s;
  logic            stk_full_s;
  logic            stk_empty_s;
  logic            ovf_set_s;
  logic            unf_set_s;
  logic            halted_r;
  logic            ovf_r;
  logic            unf_r;

  assign pc_inc_s = pc_r + PC_W'(1);
  assign pc_rel_s = pc_r + PC_W'($signed(offset_i));

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .din_i   (pc_inc_s),
    .dout_o  (stk_dout_s),
    .count_o (sp_o),
    .full_o  (stk_full_s),
    .empty_o (stk_empty_s)
  );

  // Next-state / next-PC: stall > halt > wfi > mode
  always_comb begin
    state_next = state_r;
    pc_next    = pc_r;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    case (state_r)
      S_RUN: begin
        if (stall_i) begin
          pc_next = pc_r;
        end else if (halt_core_i) begin
          state_next = S_HALTED;
        end else if (wfi_core_i) begin
          pc_next = pc_r;
        end else begin
          case (mode_pc_i)
            INCREMENT: pc_next = pc_inc_s;
            RELATIVE:  pc_next = pc_rel_s;
            SUBROUTINE: begin
              if (stk_full_s) begin
                ovf_set_s = 1'b1;
`ifdef PC_STACK_FAULT_HALT_EN
                state_next = S_HALTED;
`else
                push_s  = 1'b1;
                pc_next = target_i;
`endif
              end else begin
                push_s  = 1'b1;
                pc_next = target_i;
              end
            end
            RETURN: begin
              if (stk_empty_s) begin
                unf_set_s = 1'b1;
`ifdef PC_STACK_FAULT_HALT_EN
                state_next = S_HALTED;
`else
                pc_next = RESET_VEC;
`endif
              end else begin
                pop_s   = 1'b1;
                pc_next = stk_dout_s;
              end
            end
            default: pc_next = pc_r;
          endcase
        end
      end
      S_HALTED: state_next = S_HALTED;
      // an illegal encoding parks the core until reset
      default:  state_next = S_HALTED;
    endcase
  end

  // State, PC and sticky fault flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= S_RUN;
      pc_r     <= RESET_VEC;
      halted_r <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      state_r  <= state_next;
      pc_r     <= pc_next;
      halted_r <= (state_next == S_HALTED);
      ovf_r    <= ovf_r | ovf_set_s;
      unf_r    <= unf_r | unf_set_s;
    end
  end

  assign pc_o      = pc_r;
  assign halted_o  = halted_r;
  assign stk_ovf_o = ovf_r;
  assign stk_unf_o = unf_r;

endmodule
